// File: rtl/load_store_unit.sv
// Load/store sequencer: turns RV32I byte/half/word accesses into word-only
// memory transactions, with read-modify-write for sb/sh and fault rejection.
//
// state | meaning
// IDLE  | waiting for iReq; request fields latched on acceptance
// RD    | memory read strobe for the addressed word
// CAP   | registered memory data valid; extract load result or merge store
// WR    | memory write strobe with the final word
// DONE  | completion pulse, no fault flags
// FAULT | completion pulse with oMisaligned/oIllegal, memory untouched
module load_store_unit #(
  parameter int MEM_WORDS   = 256,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReq,
  input  logic        iWe,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic [31:0] oRData,
  output logic        oDone,
  output logic        oBusy,
  output logic        oMisaligned,
  output logic        oIllegal,
  output logic [31:0] oMemEnd,
  output logic [31:0] oMemDadoEscrita,
  output logic        oMemEscMem,
  output logic        oMemLeMem,
  input  logic [31:0] iMemDado
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [31:0] wword_q, wword_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        ill_q, ill_d;

  logic        req_legal;
  logic        req_oor;
  logic        req_mis;
  logic [15:0] lane;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    if (iWe) begin
      req_legal = (iFunct3 == 3'b000) || (iFunct3 == 3'b001) || (iFunct3 == 3'b010);
    end else begin
      req_legal = (iFunct3 == 3'b000) || (iFunct3 == 3'b001) || (iFunct3 == 3'b010) ||
                  (iFunct3 == 3'b100) || (iFunct3 == 3'b101);
    end
    req_oor = CHECK_RANGE && ({1'b0, iAddr} >= ADDR_LIMIT);
    req_mis = ((iFunct3[1:0] == 2'b01) && iAddr[0]) ||
              ((iFunct3[1:0] == 2'b10) && (iAddr[1:0] != 2'b00));
  end

  // Little-endian lane select: the addressed byte/half lands in the low bits.
  always_comb begin
    lane = 16'(iMemDado >> {addr_q[1:0], 3'b000});
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_val = {24'h000000, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_val = {16'h0000, lane[15:0]};
      default: load_val = iMemDado;
    endcase

    merged = iMemDado;
    case (f3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wword_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wword_q[15:0];
      default: merged = iMemDado;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wword_d = wword_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    ill_d   = ill_q;

    case (state_q)
      S_IDLE: begin
        if (iReq) begin
          addr_d  = iAddr;
          f3_d    = iFunct3;
          we_d    = iWe;
          wword_d = iWData;
          ill_d   = !req_legal || req_oor;
          mis_d   = req_legal && !req_oor && req_mis;
          if (ill_d || mis_d) begin
            state_d = S_FAULT;
          end else if (iWe && (iFunct3 == 3'b010)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        if (we_q) begin
          wword_d = merged;
          state_d = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WR:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wword_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wword_q <= wword_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
    end
  end

  assign oRData          = rdata_q;
  assign oDone           = (state_q == S_DONE) || (state_q == S_FAULT);
  assign oBusy           = (state_q != S_IDLE);
  assign oMisaligned     = (state_q == S_FAULT) && mis_q;
  assign oIllegal        = (state_q == S_FAULT) && ill_q;
  assign oMemEnd         = {addr_q[31:2], 2'b00};
  assign oMemDadoEscrita = wword_q;
  assign oMemLeMem       = (state_q == S_RD);
  assign oMemEscMem      = (state_q == S_WR);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts
// every completion; a monitor checks strobes and results as the DUT produces them.
module tb_load_store_unit;
  localparam int MW = 256;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iReq = 1'b0;
  logic        iWe = 1'b0;
  logic [2:0]  iFunct3 = 3'b000;
  logic [31:0] iAddr = '0;
  logic [31:0] iWData = '0;
  logic [31:0] oRData, oMemEnd, oMemDadoEscrita, iMemDado;
  logic        oDone, oBusy, oMisaligned, oIllegal, oMemEscMem, oMemLeMem;

  always #5 iCLK = ~iCLK;

  load_store_unit #(.MEM_WORDS(MW), .CHECK_RANGE(1'b1)) dut (
    .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iWe(iWe), .iFunct3(iFunct3),
    .iAddr(iAddr), .iWData(iWData), .oRData(oRData), .oDone(oDone),
    .oBusy(oBusy), .oMisaligned(oMisaligned), .oIllegal(oIllegal),
    .oMemEnd(oMemEnd), .oMemDadoEscrita(oMemDadoEscrita),
    .oMemEscMem(oMemEscMem), .oMemLeMem(oMemLeMem), .iMemDado(iMemDado)
  );

  // Word memory with registered read data; seeded from img while seed is high.
  logic [31:0] mem [MW];
  logic [31:0] img [MW];
  logic [31:0] mem_rd = '0;
  bit          seed = 1'b1;
  always @(posedge iCLK) begin
    if (seed) begin
      for (int i = 0; i < MW; i++) mem[i] <= img[i];
    end else begin
      if (oMemLeMem) mem_rd <= mem[(oMemEnd >> 2) % MW];
      if (oMemEscMem) mem[(oMemEnd >> 2) % MW] <= oMemDadoEscrita;
    end
  end
  assign iMemDado = mem_rd;

  logic [7:0] ref_b [MW*4];
  logic [31:0] last_rd = '0;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] wa;
    logic [31:0] wdat;
    bit          mis;
    bit          ill;
    int          lat;
    int          nrd;
    int          nwr;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   nrd_seen = 0;
  int   nwr_seen = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] word_at(int byte_addr);
    int b;
    b = byte_addr & ~3;
    return {ref_b[b+3], ref_b[b+2], ref_b[b+1], ref_b[b]};
  endfunction

  function automatic logic [31:0] ref_load(int a, logic [2:0] f3);
    case (f3)
      3'd0:    return {{24{ref_b[a][7]}}, ref_b[a]};
      3'd4:    return {24'h0, ref_b[a]};
      3'd1:    return {{16{ref_b[a+1][7]}}, ref_b[a+1], ref_b[a]};
      3'd5:    return {16'h0, ref_b[a+1], ref_b[a]};
      default: return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
    endcase
  endfunction

  // Monitor: strobes are attributed to the oldest outstanding access.
  always @(negedge iCLK) begin
    exp_t e;
    if (iRST) begin
      nrd_seen = 0;
      nwr_seen = 0;
    end else begin
      if (oMemLeMem || oMemEscMem) begin
        check("strobe_exclusive", 32'(oMemLeMem && oMemEscMem), 32'd0);
        if (sb_q.size() == 0) begin
          if (oMemEscMem) fail_now("write_without_access");
        end else begin
          check("mem_addr", oMemEnd, sb_q[0].wa);
          if (oMemLeMem) nrd_seen++;
          if (oMemEscMem) begin
            nwr_seen++;
            check("mem_wdata", oMemDadoEscrita, sb_q[0].wdat);
          end
        end
      end
      if (oDone) begin
        if (sb_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = sb_q.pop_front();
          check("rdata", oRData, e.rdata);
          check("misaligned", 32'(oMisaligned), 32'(e.mis));
          check("illegal", 32'(oIllegal), 32'(e.ill));
          check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          check("read_count", 32'(nrd_seen), 32'(e.nrd));
          check("write_count", 32'(nwr_seen), 32'(e.nwr));
          check("busy_in_done", 32'(oBusy), 32'd1);
        end
        nrd_seen = 0;
        nwr_seen = 0;
      end else if (sb_q.size() != 0 && cyc >= sb_q[0].acc) begin
        check("busy_during_access", 32'(oBusy), 32'd1);
      end
    end
  end

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    @(negedge iCLK);
    while (oBusy) begin
      n++;
      if (n > 40) begin
        fail_now("idle_timeout");
        ok = 1'b0;
        return;
      end
      @(negedge iCLK);
    end
  endtask

  task automatic issue(bit we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, bit hold);
    exp_t e;
    bit   ok, legal, half, word;
    wait_idle(ok);
    if (!ok) return;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    half  = (f3 == 3'd1) || (f3 == 3'd5);
    word  = (f3 == 3'd2);
    e.ill = !legal || (a >= 32'(MW * 4));
    e.mis = !e.ill && ((half && (a % 2 != 0)) || (word && (a % 4 != 0)));
    e.acc = cyc + 1;
    e.wa  = {a[31:2], 2'b00};
    e.wdat = '0;
    if (e.ill || e.mis) begin
      e.lat = 1; e.nrd = 0; e.nwr = 0;
      e.rdata = last_rd;
    end else if (!we) begin
      e.lat = 3; e.nrd = 1; e.nwr = 0;
      e.rdata = ref_load(int'(a), f3);
      last_rd = e.rdata;
    end else begin
      ref_b[int'(a)] = wd[7:0];
      if (f3 != 3'd0) ref_b[int'(a)+1] = wd[15:8];
      if (f3 == 3'd2) begin
        ref_b[int'(a)+2] = wd[23:16];
        ref_b[int'(a)+3] = wd[31:24];
      end
      e.wdat = word_at(int'(a));
      e.lat = (f3 == 3'd2) ? 2 : 4;
      e.nrd = (f3 == 3'd2) ? 0 : 1;
      e.nwr = 1;
      e.rdata = last_rd;
    end
    sb_q.push_back(e);
    iReq = 1'b1;
    iWe = we;
    iFunct3 = f3;
    iAddr = a;
    iWData = wd;
    @(posedge iCLK);
    #1;
    if (!hold) iReq = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    logic [31:0] a, wd;
    logic [2:0] f3;
    bit we;

    for (int i = 0; i < MW; i++) begin
      img[i] = $urandom;
      if (i == 20) img[i] = 32'h0000_0001;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = img[i][8*k +: 8];
    end

    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    check("rst_rdata", oRData, 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_mis", 32'(oMisaligned), 32'd0);
    check("rst_ill", 32'(oIllegal), 32'd0);
    check("rst_wr", 32'(oMemEscMem), 32'd0);
    check("rst_rd", 32'(oMemLeMem), 32'd0);
    check("rst_end", oMemEnd, 32'd0);
    check("rst_wdata", oMemDadoEscrita, 32'd0);
    seed = 1'b0;
    @(posedge iCLK);
    #1 iRST = 1'b0;

    issue(1'b0, 3'd2, 32'h50, 32'h0, 1'b0);
    issue(1'b1, 3'd2, 32'h60, 32'h8899AABB, 1'b0);
    issue(1'b0, 3'd0, 32'h61, 32'h0, 1'b0);
    issue(1'b0, 3'd4, 32'h61, 32'h0, 1'b0);
    issue(1'b0, 3'd1, 32'h62, 32'h0, 1'b0);
    issue(1'b0, 3'd5, 32'h62, 32'h0, 1'b0);
    issue(1'b1, 3'd0, 32'h63, 32'h12345611, 1'b0);
    issue(1'b0, 3'd2, 32'h60, 32'h0, 1'b0);
    issue(1'b1, 3'd1, 32'h60, 32'h0000BEEF, 1'b0);
    issue(1'b0, 3'd2, 32'h60, 32'h0, 1'b0);
    wait_idle(ok);
    check("lw_after_sh", oRData, 32'h1199BEEF);
    issue(1'b0, 3'd2, 32'h52, 32'h0, 1'b0);
    issue(1'b0, 3'd3, 32'h40, 32'h0, 1'b0);
    issue(1'b1, 3'd4, 32'h40, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h400, 32'h0, 1'b0);
    issue(1'b1, 3'd1, 32'h71, 32'h1234, 1'b0);

    // Reset during the CAP cycle of an sb must abort before any write.
    wait_idle(ok);
    iReq = 1'b1; iWe = 1'b1; iFunct3 = 3'd0; iAddr = 32'h63; iWData = 32'h000000EE;
    @(posedge iCLK);
    #1 iReq = 1'b0;
    @(posedge iCLK);
    #1 iRST = 1'b1;
    @(posedge iCLK);
    #1 iRST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge iCLK);
      check("abort_busy", 32'(oBusy), 32'd0);
      check("abort_done", 32'(oDone), 32'd0);
    end
    last_rd = '0;
    issue(1'b0, 3'd2, 32'h60, 32'h0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      issue(i % 2 == 1, 3'd2, 32'h80 + 32'(4 * (i % 3)), $urandom, i != 11);
    end

    for (int i = 0; i < 250; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
           : (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      if ($urandom_range(0, 19) == 0) a = $urandom;
      else a = 32'($urandom_range(0, MW * 4 - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      wd = $urandom;
      issue(we, f3, a, wd, 1'($urandom_range(0, 1)) && (i != 249));
    end
    iReq = 1'b0;

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    if (sb_q.size() != 0) fail_now("pending_at_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
